// File: rtl/four_phase_monitor_pkg.sv
// Shared constants and types for the 4-phase bundle monitor.
// Code bit order is {p0, p1, p2, p3}.
package four_phase_monitor_pkg;

  localparam logic [3:0] PH0_CODE = 4'b0110;
  localparam logic [3:0] PH1_CODE = 4'b0011;
  localparam logic [3:0] PH2_CODE = 4'b1001;
  localparam logic [3:0] PH3_CODE = 4'b1100;

  typedef logic [1:0] phase_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Legal iff p2 = ~p0 and p3 = ~p1.
  function automatic logic code_legal(input logic [3:0] code);
    return (code[1] == ~code[3]) && (code[0] == ~code[2]);
  endfunction

  function automatic phase_t code2phase(input logic [3:0] code);
    phase_t ph;
    case (code)
      PH1_CODE: ph = 2'd1;
      PH2_CODE: ph = 2'd2;
      PH3_CODE: ph = 2'd3;
      default:  ph = 2'd0;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/four_phase_monitor_sync_chain.sv
// Multi-flop synchroniser for a bundle of asynchronous lines, cleared on reset.
module four_phase_monitor_sync_chain #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [STAGES-1:0][W-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/four_phase_monitor.sv
// Receive-side checker for the p0..p3 quadrature bundle: decode, rotation
// check, dwell measurement, stall detection and lock tracking.
module four_phase_monitor
  import four_phase_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 8,
  parameter int DW          = 8,
  parameter int MAX_DWELL   = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          p0,
  input  logic          p1,
  input  logic          p2,
  input  logic          p3,
  input  logic          clr_err,
  output logic [1:0]    phase,
  output logic          phase_valid,
  output logic          locked,
  output logic [DW-1:0] dwell,
  output logic          err_code,
  output logic          err_seq,
  output logic          err_stall
);

  localparam int RW = $clog2(LOCK_COUNT + 1);

  logic [3:0]    w_code;
  logic          w_legal, w_first, w_change, w_fwd, w_seq, w_stall, w_ill, w_bad;
  phase_t        w_idx, w_step;
  logic [DW-1:0] w_cnt_nxt;
  state_t        r_state, w_state_nxt;
  logic [RW-1:0] r_run, w_run_nxt;
  phase_t        r_phase;
  logic          r_valid, r_seen;
  logic [DW-1:0] r_cnt, r_dwell;
  logic          r_err_code, r_err_seq, r_err_stall;

  four_phase_monitor_sync_chain #(.W(4), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   ({p0, p1, p2, p3}),
    .o_q   (w_code)
  );

  assign w_legal   = code_legal(w_code);
  assign w_idx     = code2phase(w_code);
  assign w_step    = w_idx - r_phase;
  // Until a first legal code arrives the synchroniser still shows its reset
  // zeros, so illegal-code and stall checks only start once the bundle is seen.
  assign w_first   = w_legal && !r_seen;
  assign w_change  = w_legal && r_seen && (w_idx != r_phase);
  assign w_fwd     = w_change && (w_step == 2'd1);
  assign w_seq     = w_change && (w_step != 2'd1);
  assign w_ill     = r_seen && !w_legal;
  assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + DW'(1);
  assign w_stall   = r_seen && !w_change && (w_cnt_nxt == DW'(MAX_DWELL))
                     && (r_cnt != DW'(MAX_DWELL));
  assign w_bad     = w_ill || w_seq || w_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    case (r_state)
      UNLOCKED: begin
        w_run_nxt = '0;
        if (w_legal && !w_bad) w_state_nxt = ACQUIRE;
      end
      ACQUIRE: begin
        if (w_bad) begin
          w_state_nxt = UNLOCKED;
          w_run_nxt   = '0;
        end else if (w_fwd) begin
          if (r_run == RW'(LOCK_COUNT - 1)) begin
            w_state_nxt = LOCKED;
            w_run_nxt   = '0;
          end else begin
            w_run_nxt = r_run + RW'(1);
          end
        end
      end
      LOCKED: begin
        if (w_bad) w_state_nxt = UNLOCKED;
      end
      default: begin
        w_state_nxt = UNLOCKED;
        w_run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= UNLOCKED;
      r_run       <= '0;
      r_phase     <= '0;
      r_valid     <= 1'b0;
      r_seen      <= 1'b0;
      r_cnt       <= '0;
      r_dwell     <= '0;
      r_err_code  <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_valid <= w_legal;
      if (w_legal) r_phase <= w_idx;
      if (w_first) r_seen <= 1'b1;
      if (w_first || w_change) r_cnt <= DW'(1);
      else if (r_seen)         r_cnt <= w_cnt_nxt;
      if (w_change) r_dwell <= r_cnt;
      // Set has priority over a coincident clear.
      r_err_code  <= w_ill   || (r_err_code  && !clr_err);
      r_err_seq   <= w_seq   || (r_err_seq   && !clr_err);
      r_err_stall <= w_stall || (r_err_stall && !clr_err);
    end
  end

  assign phase       = r_phase;
  assign phase_valid = r_valid;
  assign locked      = (r_state == LOCKED);
  assign dwell       = r_dwell;
  assign err_code    = r_err_code;
  assign err_seq     = r_err_seq;
  assign err_stall   = r_err_stall;

endmodule

// File: tb/tb_four_phase_monitor.sv
// Directed bench for four_phase_monitor: lock-up, skip, glitch, reverse,
// stall and mid-run reset scenarios with hand-derived expectations.
module tb_four_phase_monitor;

  logic       CLK = 1'b0;
  logic       RST, p0, p1, p2, p3, clr_err;
  logic [1:0] phase;
  logic       phase_valid, locked, err_code, err_seq, err_stall;
  logic [7:0] dwell;

  int n_chk  = 0;
  int n_pass = 0;
  int cur    = 0;
  logic [3:0] codes [4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};

  four_phase_monitor #(.SYNC_STAGES(2), .LOCK_COUNT(8), .DW(8), .MAX_DWELL(16)) dut (
    .CLK(CLK), .RST(RST), .p0(p0), .p1(p1), .p2(p2), .p3(p3), .clr_err(clr_err),
    .phase(phase), .phase_valid(phase_valid), .locked(locked), .dwell(dwell),
    .err_code(err_code), .err_seq(err_seq), .err_stall(err_stall)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_code(input logic [3:0] c);
    {p0, p1, p2, p3} = c;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Advance n forward steps, each code held two cycles.
  task automatic rotate(input int n);
    for (int i = 0; i < n; i++) begin
      cur = (cur + 1) % 4;
      set_code(codes[cur]);
      cyc(2);
    end
  endtask

  task automatic do_reset(input int idx);
    RST = 1'b1;
    cur = idx;
    set_code(codes[idx]);
    cyc(2);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; clr_err = 1'b0;
    set_code(codes[0]);
    cyc(2);
    chk("rst_phase", phase, 0);
    chk("rst_valid", phase_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_dwell", dwell, 0);
    chk("rst_errs", {err_code, err_seq, err_stall}, 0);

    // Generator-like rotation, 2 cycles per phase.
    RST = 1'b0; cur = 0;
    cyc(2);
    rotate(7); cyc(2);
    chk("acq7_locked", locked, 0);
    chk("acq7_phase", phase, 3);
    chk("acq7_valid", phase_valid, 1);
    chk("acq7_dwell", dwell, 2);
    chk("acq7_errs", {err_code, err_seq, err_stall}, 0);
    rotate(1); cyc(2);
    chk("lock8_locked", locked, 1);
    chk("lock8_phase", phase, 0);
    chk("lock8_dwell", dwell, 4);

    // Skip 0 -> 2.
    cur = 2; set_code(codes[2]); cyc(4);
    chk("skip_err_seq", err_seq, 1);
    chk("skip_locked", locked, 0);
    chk("skip_phase", phase, 2);
    cur = 3; set_code(codes[3]); cyc(4);
    chk("skip_fwd_phase", phase, 3);
    chk("skip_sticky", err_seq, 1);
    clr_err = 1'b1; cyc(1); clr_err = 1'b0; cyc(1);
    chk("clr_err_seq", err_seq, 0);

    // Relock from ACQUIRE, then a one-sample 0000 glitch.
    rotate(8); cyc(2);
    chk("relock_locked", locked, 1);
    set_code(4'b0000); cyc(1);
    set_code(codes[cur]); cyc(1);
    chk("glitch_pre_valid", phase_valid, 1);
    cyc(1);
    chk("glitch_valid", phase_valid, 0);
    chk("glitch_err_code", err_code, 1);
    chk("glitch_locked", locked, 0);
    chk("glitch_phase_hold", phase, 3);
    cyc(1);
    chk("glitch_recover", phase_valid, 1);
    chk("glitch_no_seq", err_seq, 0);

    // Relock, then asynchronous reset mid-run.
    rotate(8); cyc(2);
    chk("lock3_locked", locked, 1);
    chk("lock3_err_code", err_code, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_err_code", err_code, 0);
    chk("arst_valid", phase_valid, 0);
    chk("arst_dwell", dwell, 0);
    cyc(1);
    RST = 1'b0;
    cyc(2);
    rotate(7); cyc(2);
    chk("rl_acq7_locked", locked, 0);
    rotate(1); cyc(2);
    chk("rl_lock8_locked", locked, 1);

    // Reverse rotation 3 -> 2 -> 1.
    do_reset(3);
    cyc(4);
    chk("rev_start_phase", phase, 3);
    chk("rev_start_seq", err_seq, 0);
    set_code(codes[2]); cyc(4);
    chk("rev_err_seq", err_seq, 1);
    chk("rev_phase", phase, 2);
    set_code(codes[1]); cyc(4);
    chk("rev_phase2", phase, 1);
    chk("rev_locked", locked, 0);

    // Stall: hold 0011; counter reaches 16 on the 18th edge after release.
    do_reset(1);
    cyc(17);
    chk("stall_pre", err_stall, 0);
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
    chk("stall_set_wins", err_stall, 1);
    chk("stall_locked", locked, 0);
    cyc(2);
    chk("stall_sticky", err_stall, 1);
    chk("stall_no_code_err", err_code, 0);
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
    chk("stall_clr", err_stall, 0);
    cyc(5);
    chk("stall_once", err_stall, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
